// File: rtl/gpif_dir_arbiter_if.sv
// Handshake bundle between FIFO status logic, the direction
// arbiter and the slave-FIFO sequencer.
interface gpif_dir_arbiter_if;
  logic        rx_req;
  logic        tx_req;
  logic        xfer_beat;
  logic        xfer_done;
  logic        rx_grant;
  logic        tx_grant;
  logic [1:0]  faddr_sel;
  logic        burst_start;
  logic        burst_end_req;
  logic        abort;
  logic        busy;
  logic [15:0] rx_bursts;
  logic [15:0] tx_bursts;
  logic [7:0]  err_count;
  logic [2:0]  dbg_state;

  modport master (
    output rx_req, tx_req,
    output xfer_beat, xfer_done,
    input  rx_grant, tx_grant,
    input  faddr_sel,
    input  burst_start, burst_end_req,
    input  abort, busy,
    input  rx_bursts, tx_bursts,
    input  err_count, dbg_state
  );

  modport slave (
    input  rx_req, tx_req,
    input  xfer_beat, xfer_done,
    output rx_grant, tx_grant,
    output faddr_sel,
    output burst_start, burst_end_req,
    output abort, busy,
    output rx_bursts, tx_bursts,
    output err_count, dbg_state
  );
endinterface

// File: rtl/gpif_dir_arbiter.sv
// RX/TX direction arbiter and burst scheduler for the
// FX3 GPIF-II slave-FIFO data bus.
module gpif_dir_arbiter #(
  parameter logic [1:0] RX_ADDR    = 2'd0,
  parameter logic [1:0] TX_ADDR    = 2'd3,
  parameter int         TURNAROUND = 3,
  parameter int         MAX_BEATS  = 1024,
  parameter int         TIMEOUT    = 4096
) (
  input logic               clk,
  input logic               reset_b,
  gpif_dir_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT_RX = 3'd1,
    S_GRANT_TX = 3'd2,
    S_TURN     = 3'd3,
    S_ABORT    = 3'd4
  } state_e;

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int SW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BEATS);
  localparam logic [BW-1:0] BEAT_ONE = BW'(1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STALL_ONE = SW'(1);
  localparam logic [2:0] TURN_LAST =
    3'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  state_e          state_q, state_d;
  state_e          end_st;
  logic            last_tx_q, last_tx_d;
  logic [1:0]      faddr_q, faddr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [2:0]      turn_q, turn_d;
  logic [15:0]     rx_b_q, rx_b_d;
  logic [15:0]     tx_b_q, tx_b_d;
  logic [7:0]      err_q, err_d;
  logic            start_d;
  logic            in_grant_d;

  logic rx_grant_q, tx_grant_q;
  logic start_q, end_req_q;
  logic abort_q, busy_q;

  always_comb begin
    state_d   = state_q;
    last_tx_d = last_tx_q;
    faddr_d   = faddr_q;
    beat_d    = beat_q;
    stall_d   = stall_q;
    turn_d    = turn_q;
    rx_b_d    = rx_b_q;
    tx_b_d    = tx_b_q;
    err_d     = err_q;
    start_d   = 1'b0;
    end_st    = S_TURN;
    if (TURNAROUND == 0) end_st = S_IDLE;

    unique case (state_q)
      S_IDLE: begin
        // on a tie, serve the direction that did not go last
        if (bus.rx_req && (!bus.tx_req || last_tx_q)) begin
          state_d   = S_GRANT_RX;
          faddr_d   = RX_ADDR;
          last_tx_d = 1'b0;
          beat_d    = '0;
          stall_d   = '0;
          start_d   = 1'b1;
        end else if (bus.tx_req) begin
          state_d   = S_GRANT_TX;
          faddr_d   = TX_ADDR;
          last_tx_d = 1'b1;
          beat_d    = '0;
          stall_d   = '0;
          start_d   = 1'b1;
        end
      end
      S_GRANT_RX, S_GRANT_TX: begin
        if (bus.xfer_beat) begin
          if (beat_q != BEAT_MAX) beat_d = beat_q + BEAT_ONE;
          stall_d = '0;
        end else begin
          stall_d = stall_q + STALL_ONE;
        end
        // completion outranks a watchdog expiry in the same cycle
        if (bus.xfer_done) begin
          state_d = end_st;
          turn_d  = '0;
          if (state_q == S_GRANT_RX) rx_b_d = rx_b_q + 16'd1;
          else                       tx_b_d = tx_b_q + 16'd1;
        end else if (!bus.xfer_beat && stall_q == STALL_LAST) begin
          state_d = S_ABORT;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      S_ABORT: begin
        state_d = end_st;
        turn_d  = '0;
      end
      S_TURN: begin
        if (turn_q == TURN_LAST) state_d = S_IDLE;
        else                     turn_d  = turn_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_grant_d = (state_d == S_GRANT_RX) ||
                      (state_d == S_GRANT_TX);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= S_IDLE;
      last_tx_q  <= 1'b1;
      faddr_q    <= RX_ADDR;
      beat_q     <= '0;
      stall_q    <= '0;
      turn_q     <= '0;
      rx_b_q     <= '0;
      tx_b_q     <= '0;
      err_q      <= '0;
      rx_grant_q <= 1'b0;
      tx_grant_q <= 1'b0;
      start_q    <= 1'b0;
      end_req_q  <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_tx_q  <= last_tx_d;
      faddr_q    <= faddr_d;
      beat_q     <= beat_d;
      stall_q    <= stall_d;
      turn_q     <= turn_d;
      rx_b_q     <= rx_b_d;
      tx_b_q     <= tx_b_d;
      err_q      <= err_d;
      rx_grant_q <= (state_d == S_GRANT_RX);
      tx_grant_q <= (state_d == S_GRANT_TX);
      start_q    <= start_d;
      end_req_q  <= in_grant_d && (beat_d >= BEAT_MAX);
      abort_q    <= (state_d == S_ABORT);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign bus.rx_grant      = rx_grant_q;
  assign bus.tx_grant      = tx_grant_q;
  assign bus.faddr_sel     = faddr_q;
  assign bus.burst_start   = start_q;
  assign bus.burst_end_req = end_req_q;
  assign bus.abort         = abort_q;
  assign bus.busy          = busy_q;
  assign bus.rx_bursts     = rx_b_q;
  assign bus.tx_bursts     = tx_b_q;
  assign bus.err_count     = err_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_gpif_dir_arbiter.sv
// Directed bench for gpif_dir_arbiter: arbitration order,
// quota, watchdog, done/stall race, request drop and reset.
module tb_gpif_dir_arbiter;

  logic clk;
  logic reset_b;
  int   errors;
  int   checks;

  gpif_dir_arbiter_if bus();

  gpif_dir_arbiter #(
    .RX_ADDR   (2'd0),
    .TX_ADDR   (2'd3),
    .TURNAROUND(3),
    .MAX_BEATS (16),
    .TIMEOUT   (32)
  ) dut (
    .clk    (clk),
    .reset_b(reset_b),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (!(bus.rx_grant || bus.tx_grant) && n < 200) begin
      tick();
      n++;
    end
    chk("grant_seen", 32'(bus.rx_grant | bus.tx_grant), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.dbg_state != 3'd0 && n < 200) begin
      tick();
      n++;
    end
    chk("idle_seen", 32'(bus.dbg_state), 0);
  endtask

  initial begin
    int n;
    int k;
    int turns;
    logic exp_tx;

    errors        = 0;
    checks        = 0;
    reset_b       = 1'b0;
    bus.rx_req    = 1'b0;
    bus.tx_req    = 1'b0;
    bus.xfer_beat = 1'b0;
    bus.xfer_done = 1'b0;
    tick();
    tick();

    chk("rst_rx_grant", 32'(bus.rx_grant), 0);
    chk("rst_tx_grant", 32'(bus.tx_grant), 0);
    chk("rst_faddr", 32'(bus.faddr_sel), 0);
    chk("rst_start", 32'(bus.burst_start), 0);
    chk("rst_end_req", 32'(bus.burst_end_req), 0);
    chk("rst_abort", 32'(bus.abort), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rx_bursts", 32'(bus.rx_bursts), 0);
    chk("rst_tx_bursts", 32'(bus.tx_bursts), 0);
    chk("rst_err", 32'(bus.err_count), 0);
    chk("rst_state", 32'(bus.dbg_state), 0);

    // round robin with both requests held
    reset_b    = 1'b1;
    bus.rx_req = 1'b1;
    bus.tx_req = 1'b1;
    wait_grant(n);
    chk("rr_latency", n, 1);
    for (int b = 0; b < 4; b++) begin
      exp_tx = (b % 2) == 1;
      chk("rr_rx_grant", 32'(bus.rx_grant), 32'(!exp_tx));
      chk("rr_tx_grant", 32'(bus.tx_grant), 32'(exp_tx));
      chk("rr_faddr", 32'(bus.faddr_sel), exp_tx ? 3 : 0);
      chk("rr_start", 32'(bus.burst_start), 1);
      chk("rr_busy", 32'(bus.busy), 1);
      for (int i = 0; i < 8; i++) begin
        bus.xfer_beat = 1'b1;
        bus.xfer_done = (i == 7);
        tick();
        if (i == 0) chk("rr_start_pulse", 32'(bus.burst_start), 0);
      end
      bus.xfer_beat = 1'b0;
      bus.xfer_done = 1'b0;
      chk("rr_end_req", 32'(bus.burst_end_req), 0);
      chk("rr_drop", 32'(bus.rx_grant | bus.tx_grant), 0);
      if (b < 3) begin
        n = 0;
        turns = 0;
        while (!(bus.rx_grant || bus.tx_grant) && n < 50) begin
          if (bus.dbg_state == 3'd3) turns++;
          tick();
          n++;
        end
        chk("rr_turn_cycles", turns, 3);
        chk("rr_gap", n, 4);
      end else begin
        bus.rx_req = 1'b0;
        bus.tx_req = 1'b0;
      end
    end
    chk("rr_rx_bursts", 32'(bus.rx_bursts), 2);
    chk("rr_tx_bursts", 32'(bus.tx_bursts), 2);
    wait_idle();
    chk("rr_idle_busy", 32'(bus.busy), 0);

    // beat quota of 16 on a TX burst
    bus.tx_req = 1'b1;
    wait_grant(n);
    chk("q_tx_grant", 32'(bus.tx_grant), 1);
    chk("q_faddr", 32'(bus.faddr_sel), 3);
    bus.tx_req = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus.xfer_beat = 1'b1;
      tick();
      chk("q_end_req", 32'(bus.burst_end_req), 32'(i >= 15));
    end
    bus.xfer_beat = 1'b0;
    tick();
    chk("q_end_req_hold", 32'(bus.burst_end_req), 1);
    bus.xfer_done = 1'b1;
    tick();
    bus.xfer_done = 1'b0;
    chk("q_end_req_clr", 32'(bus.burst_end_req), 0);
    chk("q_tx_bursts", 32'(bus.tx_bursts), 3);
    wait_idle();

    // watchdog: RX granted, no beats
    bus.rx_req = 1'b1;
    wait_grant(n);
    chk("wd_rx_grant", 32'(bus.rx_grant), 1);
    bus.rx_req = 1'b0;
    bus.tx_req = 1'b1;
    k = 1;
    while (!bus.abort && k < 100) begin
      tick();
      k++;
    end
    chk("wd_abort_cycle", k, 33);
    chk("wd_abort_grants", 32'(bus.rx_grant | bus.tx_grant), 0);
    chk("wd_abort_state", 32'(bus.dbg_state), 4);
    tick();
    chk("wd_abort_pulse", 32'(bus.abort), 0);
    chk("wd_turn_state", 32'(bus.dbg_state), 3);
    chk("wd_err", 32'(bus.err_count), 1);
    chk("wd_rx_bursts", 32'(bus.rx_bursts), 2);
    wait_grant(n);
    chk("wd_next_tx", 32'(bus.tx_grant), 1);
    chk("wd_next_faddr", 32'(bus.faddr_sel), 3);
    bus.tx_req    = 1'b0;
    bus.xfer_done = 1'b1;
    tick();
    bus.xfer_done = 1'b0;
    chk("wd_tx_bursts", 32'(bus.tx_bursts), 4);
    wait_idle();

    // done lands on the last stall cycle
    bus.rx_req = 1'b1;
    wait_grant(n);
    chk("race_rx_grant", 32'(bus.rx_grant), 1);
    bus.rx_req = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    chk("race_still_grant", 32'(bus.rx_grant), 1);
    bus.xfer_done = 1'b1;
    tick();
    bus.xfer_done = 1'b0;
    chk("race_no_abort", 32'(bus.abort), 0);
    chk("race_state", 32'(bus.dbg_state), 3);
    chk("race_rx_bursts", 32'(bus.rx_bursts), 3);
    tick();
    chk("race_no_abort2", 32'(bus.abort), 0);
    chk("race_err", 32'(bus.err_count), 1);
    wait_idle();

    // request dropped mid-burst keeps the grant
    bus.rx_req = 1'b1;
    wait_grant(n);
    for (int i = 0; i < 2; i++) begin
      bus.xfer_beat = 1'b1;
      tick();
    end
    bus.xfer_beat = 1'b0;
    bus.rx_req    = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("drop_held", 32'(bus.rx_grant), 1);
    bus.xfer_done = 1'b1;
    tick();
    bus.xfer_done = 1'b0;
    chk("drop_released", 32'(bus.rx_grant), 0);
    chk("drop_rx_bursts", 32'(bus.rx_bursts), 4);
    wait_idle();

    // asynchronous reset during a TX grant
    bus.tx_req = 1'b1;
    wait_grant(n);
    chk("ar_tx_grant", 32'(bus.tx_grant), 1);
    for (int i = 0; i < 3; i++) begin
      bus.xfer_beat = 1'b1;
      tick();
    end
    #3;
    reset_b = 1'b0;
    #1;
    chk("ar_tx_grant0", 32'(bus.tx_grant), 0);
    chk("ar_busy", 32'(bus.busy), 0);
    chk("ar_faddr", 32'(bus.faddr_sel), 0);
    chk("ar_state", 32'(bus.dbg_state), 0);
    chk("ar_abort", 32'(bus.abort), 0);
    chk("ar_rx_bursts", 32'(bus.rx_bursts), 0);
    chk("ar_tx_bursts", 32'(bus.tx_bursts), 0);
    chk("ar_err", 32'(bus.err_count), 0);
    bus.xfer_beat = 1'b0;
    bus.rx_req    = 1'b1;
    bus.tx_req    = 1'b1;
    tick();
    tick();
    reset_b = 1'b1;
    wait_grant(n);
    chk("ar_tie_rx", 32'(bus.rx_grant), 1);
    chk("ar_tie_faddr", 32'(bus.faddr_sel), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
